aes_stream_ctrl: RTL and testbench

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

---
 rtl/aes_stream_ctrl_pkg.sv | 38 +++
 rtl/aes_stream_ctrl_if.sv | 24 ++
 rtl/aes_stream_ctrl_serializer.sv | 60 ++++++
 rtl/aes_stream_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_stream_ctrl_pkg.sv
// Shared definitions for the AES stream controller.
// Holds the FSM state encoding, key-length codes, round counts and two small
// helpers that turn a key-length code into NR and NR into the last key-word index.
package aes_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_KEY  = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_START     = 3'd3,
    ST_RUN       = 3'd4,
    ST_OUT       = 3'd5
  } aes_state_e;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Code 2'b11 is not a real key length and falls back to AES-128.
  function automatic logic [3:0] nr_from_key_len(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: return NR_128;
      KEY_LEN_192: return NR_192;
      KEY_LEN_256: return NR_256;
      default:     return NR_128;
    endcase
  endfunction

  // Key words are 4/6/8 for NR 10/12/14, so the last word index is NR-7.
  function automatic logic [2:0] key_last_idx(input logic [3:0] nr);
    return 3'(nr - 4'd7);
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Word-stream interface of the AES stream controller.
// Inbound: i_word/i_valid/o_ready plus the per-job i_key_len and i_reuse_key.
// Outbound: o_word/o_valid/i_ready ciphertext words.
// slave = the controller, master = the side feeding and draining it.
interface aes_stream_ctrl_if;
  logic [31:0] i_word;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_key_len;
  logic        i_reuse_key;
  logic [31:0] o_word;
  logic        o_valid;
  logic        i_ready;

  modport master (
    output i_word, i_valid, i_key_len, i_reuse_key, i_ready,
    input  o_ready, o_word, o_valid
  );

  modport slave (
    input  i_word, i_valid, i_key_len, i_reuse_key, i_ready,
    output o_ready, o_word, o_valid
  );
endinterface

// File: rtl/aes_stream_ctrl_serializer.sv
// aes_word_serializer: captures a 128-bit block and emits it as four 32-bit
// words, most significant first, over a valid/ready handshake.
// Ports: clk, rst (sync, active-high), i_load/i_data (capture strobe + block),
//        o_word/o_valid/i_ready (word handshake), o_done (high on the 4th handshake).
module aes_word_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [127:0] i_data,
  output logic [31:0]  o_word,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_done
);

  logic [127:0] cap_q, cap_d;
  logic [2:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         xfer_s;

  assign xfer_s = valid_q && i_ready;

  // Load the block, or shift the next word up to the top on each handshake.
  always_comb begin
    cap_d   = cap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (i_load) begin
      cap_d   = i_data;
      idx_d   = 3'd0;
      valid_d = 1'b1;
    end else if (xfer_s) begin
      cap_d   = {cap_q[95:0], 32'd0};
      idx_d   = idx_q + 3'd1;
      valid_d = (idx_q != 3'd3);
    end else begin
      cap_d   = cap_q;
    end
  end

  // Capture register, word index and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q   <= 128'd0;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // The word on the bus is always the top of the shift register, so it is
  // held for as long as the consumer stalls.
  assign o_word  = cap_q[127:96];
  assign o_valid = valid_q;
  assign o_done  = xfer_s && (idx_q == 3'd3);

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: collects key and plaintext words, starts the cipher core,
// waits for its fixed latency, captures the ciphertext and streams it out.
// Ports: clk, rst (sync, active-high); s_if (word streams, slave side);
//        o_key/o_NR/o_block/o_sync to the cipher core, i_cipher_data from it;
//        o_busy high whenever a job is in progress.
// LAT_ADJ: signed extra cycles added to the NR-1 cycle wait in RUN.
module aes_stream_ctrl
  import aes_stream_ctrl_pkg::*;
#(
  parameter int LAT_ADJ = 0
) (
  input  logic              clk,
  input  logic              rst,
  aes_stream_ctrl_if.slave  s_if,
  output logic [255:0]      o_key,
  output logic [3:0]        o_NR,
  output logic [127:0]      o_block,
  output logic              o_sync,
  input  logic [127:0]      i_cipher_data,
  output logic              o_busy
);

  aes_state_e   state_q, state_d;
  logic [2:0]   wcnt_q, wcnt_d;
  logic [3:0]   run_cnt_q, run_cnt_d;
  logic         key_valid_q, key_valid_d;
  logic [255:0] key_q, key_d;
  logic [127:0] block_q, block_d;
  logic [3:0]   nr_q, nr_d;
  logic         ready_q, ready_d;
  logic         sync_q, sync_d;
  logic         busy_q, busy_d;
  logic         accept_s, load_s, done_s;
  int           run_len_s;
  logic [3:0]   run_last_s;

  assign accept_s = s_if.i_valid && ready_q;

  // RUN length NR-1+LAT_ADJ, clamped to 1..16 so the 4-bit counter can hold it.
  always_comb begin
    run_len_s = int'(nr_q) - 1 + LAT_ADJ;
    if (run_len_s < 1) begin
      run_len_s = 1;
    end else if (run_len_s > 16) begin
      run_len_s = 16;
    end else begin
      run_len_s = run_len_s;
    end
    run_last_s = 4'(run_len_s - 1);
  end

  // Next-state, datapath and registered-output decode for the job FSM.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    run_cnt_d   = run_cnt_q;
    key_valid_d = key_valid_q;
    key_d       = key_q;
    block_d     = block_q;
    nr_d        = nr_q;
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          wcnt_d = 3'd1;
          if (s_if.i_reuse_key && key_valid_q) begin
            block_d = {s_if.i_word, 96'd0};
            state_d = ST_LOAD_DATA;
          end else begin
            // New key: clear the tail so shorter keys leave low bits zero,
            // and drop key_valid until the whole key is in.
            key_d       = {s_if.i_word, 224'd0};
            nr_d        = nr_from_key_len(s_if.i_key_len);
            key_valid_d = 1'b0;
            state_d     = ST_LOAD_KEY;
          end
        end else begin
          wcnt_d = 3'd0;
        end
      end
      ST_LOAD_KEY: begin
        if (accept_s) begin
          key_d[9'd255 - {1'b0, wcnt_q, 5'd0} -: 32] = s_if.i_word;
          if (wcnt_q == key_last_idx(nr_q)) begin
            wcnt_d      = 3'd0;
            key_valid_d = 1'b1;
            state_d     = ST_LOAD_DATA;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      ST_LOAD_DATA: begin
        if (accept_s) begin
          block_d[8'd127 - {1'b0, wcnt_q[1:0], 5'd0} -: 32] = s_if.i_word;
          if (wcnt_q == 3'd3) begin
            wcnt_d  = 3'd0;
            state_d = ST_START;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      ST_START: begin
        run_cnt_d = 4'd0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // The core's result is valid on the edge that ends the last count.
        if (run_cnt_q == run_last_s) begin
          load_s  = 1'b1;
          state_d = ST_OUT;
        end else begin
          run_cnt_d = run_cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they are exact in the cycle
    // the state is entered.
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD_KEY) || (state_d == ST_LOAD_DATA);
    sync_d  = (state_d == ST_START);
    busy_d  = (state_d != ST_IDLE);
  end

  // Job FSM state, counters, key/block registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 3'd0;
      run_cnt_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_q       <= 256'd0;
      block_q     <= 128'd0;
      nr_q        <= NR_128;
      ready_q     <= 1'b0;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      run_cnt_q   <= run_cnt_d;
      key_valid_q <= key_valid_d;
      key_q       <= key_d;
      block_q     <= block_d;
      nr_q        <= nr_d;
      ready_q     <= ready_d;
      sync_q      <= sync_d;
      busy_q      <= busy_d;
    end
  end

  aes_word_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (load_s),
    .i_data  (i_cipher_data),
    .o_word  (s_if.o_word),
    .o_valid (s_if.o_valid),
    .i_ready (s_if.i_ready),
    .o_done  (done_s)
  );

  assign s_if.o_ready = ready_q;
  assign o_key        = key_q;
  assign o_NR         = nr_q;
  assign o_block      = block_q;
  assign o_sync       = sync_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Testbench for aes_stream_ctrl: drives randomized jobs (bubbles, back-pressure,
// key reuse, mid-job reset) and acts as the cipher-core stub, comparing every
// output against a job-level reference model.
module tb_aes_stream_ctrl;

  localparam int LAT_ADJ = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] o_key;
  logic [3:0]   o_NR;
  logic [127:0] o_block;
  logic         o_sync;
  logic [127:0] i_cipher_data;
  logic         o_busy;

  aes_stream_ctrl_if bus ();

  aes_stream_ctrl #(.LAT_ADJ(LAT_ADJ)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_if          (bus.slave),
    .o_key         (o_key),
    .o_NR          (o_NR),
    .o_block       (o_block),
    .o_sync        (o_sync),
    .i_cipher_data (i_cipher_data),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: what the controller should currently hold.
  bit           m_key_valid;
  logic [255:0] m_key;
  logic [3:0]   m_nr;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    @(negedge clk);
    check_val("rst_ready", bus.o_ready, 1'b0);
    check_val("rst_sync", o_sync, 1'b0);
    check_val("rst_valid", bus.o_valid, 1'b0);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_key", o_key, 256'd0);
    check_val("rst_block", o_block, 128'd0);
    check_val("rst_nr", o_NR, 4'd10);
    check_val("rst_word", bus.o_word, 32'd0);
    rst = 1'b0;
    m_key_valid = 1'b0;
    m_key = 256'd0;
    m_nr = 4'd10;
  endtask

  // Offer one word after a random bubble and wait (bounded) for acceptance.
  task automatic send_word(input logic [31:0] w, input logic [1:0] klen, input bit reuse);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    bus.i_word = w;
    bus.i_valid = 1'b1;
    bus.i_key_len = klen;
    bus.i_reuse_key = reuse;
    for (int t = 0; t < 50 && !bus.o_ready; t++) @(negedge clk);
    if (!bus.o_ready) check_val("ready_timeout", bus.o_ready, 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_word = $urandom;
  endtask

  task automatic run_job(input bit reuse, input logic [1:0] klen, input logic [255:0] key_in,
                         input logic [127:0] data, input logic [127:0] ct,
                         input int stall_idx, input bit abort);
    bit first;
    int nwords, r, idx, budget, stall;
    bit rdy;
    first = 1'b1;
    if (!(reuse && m_key_valid)) begin
      m_nr = (klen == 2'b01) ? 4'd12 : (klen == 2'b10) ? 4'd14 : 4'd10;
      nwords = (m_nr == 4'd12) ? 6 : (m_nr == 4'd14) ? 8 : 4;
      m_key = 256'd0;
      for (int i = 0; i < nwords; i++) begin
        m_key[255 - 32*i -: 32] = key_in[255 - 32*i -: 32];
        send_word(key_in[255 - 32*i -: 32], first ? klen : 2'($urandom_range(0, 3)),
                  first ? reuse : 1'($urandom_range(0, 1)));
        first = 1'b0;
      end
      m_key_valid = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      send_word(data[127 - 32*i -: 32], first ? klen : 2'($urandom_range(0, 3)),
                first ? reuse : 1'($urandom_range(0, 1)));
      first = 1'b0;
    end
    // START cycle
    check_val("key", o_key, m_key);
    check_val("block", o_block, data);
    check_val("nr", o_NR, m_nr);
    if (m_nr == 4'd12) check_val("key192_low", o_key[63:0], 64'd0);
    check_val("sync_start", o_sync, 1'b1);
    check_val("start_ready", bus.o_ready, 1'b0);
    bus.i_valid = 1'b1;
    r = int'(m_nr) - 1 + LAT_ADJ;
    for (int c = 1; c <= r; c++) begin
      @(negedge clk);
      i_cipher_data = (c == r) ? ct : rnd128();
      if (c == r) bus.i_valid = 1'b0;
      check_val("run_sync", o_sync, 1'b0);
      check_val("run_valid", bus.o_valid, 1'b0);
      check_val("run_ready", bus.o_ready, 1'b0);
      if (abort && c == 2) begin
        do_reset();
        return;
      end
    end
    check_val("key_hold", o_key, m_key);
    check_val("block_hold", o_block, data);
    @(negedge clk);
    i_cipher_data = rnd128();
    check_val("valid_first", bus.o_valid, 1'b1);
    check_val("out_sync", o_sync, 1'b0);
    idx = 0;
    budget = 200;
    stall = 0;
    while (idx < 4 && budget > 0) begin
      check_val("out_valid", bus.o_valid, 1'b1);
      check_val($sformatf("word%0d", idx), bus.o_word, ct[127 - 32*idx -: 32]);
      if (idx == stall_idx && stall < 20) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      bus.i_ready = rdy;
      @(negedge clk);
      i_cipher_data = rnd128();
      budget--;
      if (rdy) idx++;
    end
    bus.i_ready = 1'b0;
    if (idx < 4) check_val("out_timeout", idx, 4);
    check_val("end_valid", bus.o_valid, 1'b0);
    check_val("end_busy", o_busy, 1'b0);
    check_val("end_ready", bus.o_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_word = 32'd0;
    bus.i_key_len = 2'b00;
    bus.i_reuse_key = 1'b0;
    i_cipher_data = 128'd0;
    repeat (2) @(negedge clk);
    do_reset();
    run_job(1'b0, 2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'd0},
            128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, 1'b0);
    run_job(1'b0, 2'b10, rnd256(), rnd128(), rnd128(), -1, 1'b0);
    run_job(1'b0, 2'b01, rnd256(), rnd128(), rnd128(), -1, 1'b0);
    run_job(1'b1, 2'($urandom_range(0, 3)), rnd256(), rnd128(), rnd128(), 2, 1'b0);
    run_job(1'b0, 2'b11, rnd256(), rnd128(), rnd128(), -1, 1'b0);
    run_job(1'b1, 2'b00, rnd256(), rnd128(), rnd128(), -1, 1'b1);
    run_job(1'b1, 2'b10, rnd256(), rnd128(), rnd128(), -1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      run_job(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd256(), rnd128(), rnd128(),
              $urandom_range(0, 5) - 1, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
